time_of_day_counter: RTL and testbench

- Downstream consumer of the LED/tick clock divider's toggling output.
- Turns each rising edge of that square wave into one elapsed second and keeps a 24-hour time of day in BCD (HH:MM:SS).
- Supports a set mode, in which single-cycle button pulses advance the minutes and hours.
- Feeds the seven-segment display driver, and feeds alarm logic through `sec_pulse` and `midnight`.

---
 rtl/time_of_day_counter.sv | 137 +++++++++++++
 tb/tb_time_of_day_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter driven by the rising edges of the divider's tick output.
// The FSM runs the clock or lets the user set the hours and minutes with button pulses.
module time_of_day_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_pulse,
    output logic       midnight,
    output logic       setting
);

    typedef enum logic {RUNNING, SETTING} state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;
    logic                   tick_evt;

    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic [2:0] sec_tens_nx;
    logic [3:0] sec_ones_nx;
    logic [2:0] min_tens_nx;
    logic [3:0] min_ones_nx;
    logic [1:0] hr_tens_nx;
    logic [3:0] hr_ones_nx;

    // Flops reset high because the divider output is high after its own reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            hist   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_evt = sync_q[SYNC_STAGES-1] & ~hist;

    always_comb begin
        sec_wrap    = (sec_tens == 3'd5) && (sec_ones == 4'd9);
        min_wrap    = (min_tens == 3'd5) && (min_ones == 4'd9);
        hr_wrap     = (hr_tens == 2'd2) && (hr_ones == 4'd3);

        sec_ones_nx = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
        sec_tens_nx = sec_tens;
        if (sec_ones == 4'd9)
            sec_tens_nx = (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;

        min_ones_nx = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
        min_tens_nx = min_tens;
        if (min_ones == 4'd9)
            min_tens_nx = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;

        hr_tens_nx  = hr_tens;
        hr_ones_nx  = hr_ones + 4'd1;
        if (hr_wrap) begin
            hr_tens_nx = 2'd0;
            hr_ones_nx = 4'd0;
        end else if (hr_ones == 4'd9) begin
            hr_tens_nx = hr_tens + 2'd1;
            hr_ones_nx = 4'd0;
        end
    end

    // Entering SETTING takes priority over a tick arriving on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUNNING;
            setting   <= 1'b0;
            sec_pulse <= 1'b0;
            midnight  <= 1'b0;
            hr_tens   <= 2'd0;
            hr_ones   <= 4'd0;
            min_tens  <= 3'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 3'd0;
            sec_ones  <= 4'd0;
        end else begin
            sec_pulse <= 1'b0;
            midnight  <= 1'b0;
            case (state)
                RUNNING: begin
                    if (set_mode) begin
                        state    <= SETTING;
                        setting  <= 1'b1;
                        sec_tens <= 3'd0;
                        sec_ones <= 4'd0;
                    end else if (tick_evt && run) begin
                        sec_pulse <= 1'b1;
                        sec_tens  <= sec_tens_nx;
                        sec_ones  <= sec_ones_nx;
                        if (sec_wrap) begin
                            min_tens <= min_tens_nx;
                            min_ones <= min_ones_nx;
                            if (min_wrap) begin
                                hr_tens  <= hr_tens_nx;
                                hr_ones  <= hr_ones_nx;
                                midnight <= hr_wrap;
                            end
                        end
                    end
                end
                SETTING: begin
                    if (!set_mode) begin
                        state   <= RUNNING;
                        setting <= 1'b0;
                    end
                    if (inc_min) begin
                        min_tens <= min_tens_nx;
                        min_ones <= min_ones_nx;
                    end
                    if (inc_hr) begin
                        hr_tens <= hr_tens_nx;
                        hr_ones <= hr_ones_nx;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed phases with randomized tick timing and set pulses,
// compared every cycle against a model that keeps the time as seconds since midnight.
module tb_time_of_day_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       run;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hr;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_pulse;
    logic       midnight;
    logic       setting;

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;
    int mid_count = 0;

    int exp_secs;
    bit exp_setting;
    bit exp_pulse;
    bit exp_mid;
    bit samples[$];

    time_of_day_counter #(.SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick_in  (tick_in),
        .run      (run),
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .sec_pulse(sec_pulse),
        .midnight (midnight),
        .setting  (setting)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge of the reference: a tick counts when the tick_in sample two edges back
    // is high and the one before it was low; the rule set works on whole seconds.
    task automatic model_step();
        bit evt;
        int h;
        int m;
        if (reset) begin
            exp_secs    = 0;
            exp_setting = 0;
            exp_pulse   = 0;
            exp_mid     = 0;
            samples     = '{1'b1, 1'b1, 1'b1};
            return;
        end
        evt = samples[samples.size()-2] && !samples[samples.size()-3];
        samples.push_back(tick_in);
        if (samples.size() > 8) void'(samples.pop_front());
        exp_pulse = 0;
        exp_mid   = 0;
        if (!exp_setting) begin
            if (set_mode) begin
                exp_setting = 1;
                exp_secs    = exp_secs - (exp_secs % 60);
            end else if (evt && run) begin
                exp_pulse = 1;
                exp_mid   = (exp_secs == 86399);
                exp_secs  = (exp_secs + 1) % 86400;
            end
        end else begin
            if (!set_mode) exp_setting = 0;
            h = exp_secs / 3600;
            m = (exp_secs / 60) % 60;
            if (inc_min) m = (m + 1) % 60;
            if (inc_hr) h = (h + 1) % 24;
            exp_secs = h * 3600 + m * 60;
        end
    endtask

    task automatic checkOutput();
        int h;
        int m;
        int s;
        h = exp_secs / 3600;
        m = (exp_secs / 60) % 60;
        s = exp_secs % 60;
        check("hr_tens", hr_tens, h / 10);
        check("hr_ones", hr_ones, h % 10);
        check("min_tens", min_tens, m / 10);
        check("min_ones", min_ones, m % 10);
        check("sec_tens", sec_tens, s / 10);
        check("sec_ones", sec_ones, s % 10);
        check("sec_pulse", sec_pulse, exp_pulse);
        check("midnight", midnight, exp_mid);
        check("setting", setting, exp_setting);
    endtask

    task automatic step_clock();
        @(posedge clock);
        model_step();
        #1;
        checkOutput();
        if (sec_pulse === 1'b1) pulse_count++;
        if (midnight === 1'b1) mid_count++;
    endtask

    task automatic applyStimulus(input logic t, input logic r, input logic s,
                                 input logic im, input logic ih, input int n);
        tick_in  = t;
        run      = r;
        set_mode = s;
        inc_min  = im;
        inc_hr   = ih;
        repeat (n) step_clock();
    endtask

    // Rising edges on tick_in; hi/lo of 0 picks a random phase length. Rests high afterwards.
    task automatic tick_edges(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, run, set_mode, 1'b0, 1'b0, (lo == 0) ? int'($urandom_range(1, 5)) : lo);
            applyStimulus(1'b1, run, set_mode, 1'b0, 1'b0, (hi == 0) ? int'($urandom_range(1, 5)) : hi);
        end
        applyStimulus(1'b1, run, set_mode, 1'b0, 1'b0, 3);
    endtask

    // Randomly interleaved set pulses with tick_in toggling underneath.
    task automatic pulse_incs(input int n_min, input int n_hr);
        int rm = n_min;
        int rh = n_hr;
        logic im;
        logic ih;
        while (rm > 0 || rh > 0) begin
            im = (rm > 0) && ($urandom_range(0, 1) == 1);
            ih = (rh > 0) && ($urandom_range(0, 1) == 1);
            if (!im && !ih) begin
                if (rm > 0) im = 1'b1;
                else ih = 1'b1;
            end
            if (im) rm--;
            if (ih) rh--;
            applyStimulus(1'($urandom_range(0, 1)), run, 1'b1, im, ih, 1);
            applyStimulus(1'($urandom_range(0, 1)), run, 1'b1, 1'b0, 1'b0, $urandom_range(0, 2));
        end
        applyStimulus(1'b1, run, 1'b1, 1'b0, 1'b0, 3);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        check("reset_sec_ones", sec_ones, 0);
        check("reset_hr_ones", hr_ones, 0);
        check("reset_pulses", pulse_count, 0);

        pulse_count = 0;
        tick_edges(3, 4, 4);
        check("run3_sec_ones", sec_ones, 3);
        check("run3_pulses", pulse_count, 3);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        pulse_incs(59, 23);
        check("set_hr_tens", hr_tens, 2);
        check("set_hr_ones", hr_ones, 3);
        check("set_min_tens", min_tens, 5);
        check("set_min_ones", min_ones, 9);
        check("set_sec_ones", sec_ones, 0);
        check("set_setting", setting, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        tick_edges(1, 0, 0);
        check("after_set_sec_ones", sec_ones, 1);
        check("after_set_min_ones", min_ones, 9);
        pulse_count = 0;
        mid_count   = 0;
        tick_edges(59, 0, 0);
        check("midnight_hr_tens", hr_tens, 0);
        check("midnight_min_tens", min_tens, 0);
        check("midnight_sec_ones", sec_ones, 0);
        check("midnight_count", mid_count, 1);
        check("midnight_pulses", pulse_count, 59);

        pulse_count = 0;
        mid_count   = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        pulse_incs(59, 0);
        check("wrap_pre_min_tens", min_tens, 5);
        pulse_incs(1, 0);
        check("wrap_min_tens", min_tens, 0);
        check("wrap_min_ones", min_ones, 0);
        check("wrap_hr_ones", hr_ones, 0);
        pulse_incs(0, 23);
        check("wrap_pre_hr_ones", hr_ones, 3);
        pulse_incs(0, 1);
        check("wrap_hr_tens", hr_tens, 0);
        check("wrap_hr_ones_zero", hr_ones, 0);
        tick_edges(4, 0, 0);
        check("setting_sec_ones", sec_ones, 0);
        check("setting_pulses", pulse_count, 0);
        check("setting_midnight", mid_count, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        tick_edges(5, 0, 0);
        check("run0_sec_ones", sec_ones, 0);
        check("run0_pulses", pulse_count, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        tick_edges(1, 0, 0);
        check("run1_sec_ones", sec_ones, 1);
        check("run1_pulses", pulse_count, 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        check("race_sec_ones", sec_ones, 0);
        check("race_pulse", sec_pulse, 0);
        check("race_setting", setting, 1);
        pulse_incs(34, 12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        tick_edges(56, 0, 0);
        check("t123456_hr", {hr_tens, hr_ones}, {2'd1, 4'd2});
        check("t123456_min", {min_tens, min_ones}, {3'd3, 4'd4});
        check("t123456_sec", {sec_tens, sec_ones}, {3'd5, 4'd6});

        pulse_count = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("midtick_reset_sec", sec_ones, 0);
        check("midtick_reset_min", min_ones, 0);
        check("midtick_reset_setting", setting, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
        check("midtick_reset_pulses", pulse_count, 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        pulse_incs(3, 2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        check("midset_reset_setting", setting, 0);
        check("midset_reset_min", min_ones, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
